// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// cpu_run_controller: run/stop sequencer for a LEGv8 core (reset, budget, halt)
// Rev 1.0
// ============================================================================
module cpu_run_controller #(
  parameter int NUM_REGS     = 8,
  parameter int REG_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 100,
  parameter int STALL_LIMIT  = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_pc,
  input  logic [NUM_REGS*REG_WIDTH-1:0] i_reg_taps,
  input  logic [$clog2(NUM_REGS)-1:0]   i_rd_sel,
  output logic                          o_core_reset,
  output logic                          o_running,
  output logic                          o_done,
  output logic                          o_timeout,
  output logic [31:0]                   o_cycle_count,
  output logic [REG_WIDTH-1:0]          o_rd_data
);

  localparam int c_SEL_W   = $clog2(NUM_REGS);
  localparam int c_HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int c_STALL_W = $clog2(STALL_LIMIT);
  localparam int c_TAP_W   = NUM_REGS * REG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_HOLD = 3'd1,
    S_RUN        = 3'd2,
    S_HALTED     = 3'd3,
    S_TIMED_OUT  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [c_HOLD_W-1:0]     r_hold_cnt;
  logic [c_STALL_W-1:0]    r_stall_cnt;
  logic [ADDR_WIDTH-1:0]   r_pc_prev;
  logic                    r_pc_valid;
  logic [31:0]             r_cycle_count;
  logic                    r_core_reset;
  logic                    r_running;
  logic                    r_done;
  logic                    r_timeout;
  logic [c_TAP_W-1:0]      r_snap;

  logic                    w_pc_same;
  logic                    w_halt;
  logic                    w_budget;
  logic                    w_hold_last;
  logic [REG_WIDTH-1:0]    w_rd_data;

  // pc_prev is stale on the first RUN cycle, so equality only counts once pc_valid is set
  assign w_pc_same   = r_pc_valid && (i_pc == r_pc_prev);
  assign w_halt      = w_pc_same && (r_stall_cnt == c_STALL_W'(STALL_LIMIT - 1));
  assign w_budget    = (r_cycle_count == 32'(MAX_CYCLES - 1));
  assign w_hold_last = (r_hold_cnt == c_HOLD_W'(RESET_CYCLES - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_hold_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_pc_prev     <= '0;
      r_pc_valid    <= 1'b0;
      r_cycle_count <= '0;
      r_core_reset  <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_snap        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED, S_TIMED_OUT: begin
          if (i_start) begin
            r_state       <= S_RESET_HOLD;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_stall_cnt   <= '0;
            r_pc_valid    <= 1'b0;
            r_core_reset  <= 1'b1;
            r_running     <= 1'b0;
          end
        end

        S_RESET_HOLD: begin
          if (w_hold_last) begin
            r_state      <= S_RUN;
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        S_RUN: begin
          r_pc_prev   <= i_pc;
          r_pc_valid  <= 1'b1;
          r_stall_cnt <= w_pc_same ? r_stall_cnt + 1'b1 : '0;
          // halt has priority over an exhausted budget on the same cycle
          if (w_halt) begin
            r_state      <= S_HALTED;
            r_done       <= 1'b1;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_snap       <= i_reg_taps;
          end else if (w_budget) begin
            r_state      <= S_TIMED_OUT;
            r_timeout    <= 1'b1;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_snap       <= i_reg_taps;
          end else if (r_cycle_count != 32'hFFFF_FFFF) begin
            r_cycle_count <= r_cycle_count + 32'd1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_core_reset <= 1'b1;
          r_running    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rd_sel == c_SEL_W'(i)) begin
        w_rd_data = r_snap[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign o_core_reset  = r_core_reset;
  assign o_running     = r_running;
  assign o_done        = r_done;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;
  assign o_rd_data     = w_rd_data;

endmodule
`default_nettype wire
